// File: rtl/d_empn_rd_arb_pkg.sv
// d_arb_defs: shared FSM state encodings and arbitration mode constants.
package d_arb_defs;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
endpackage

// File: rtl/d_empn_rd_arb_pick.sv
// d_arb_pick: combinational priority picker, fixed or rotating from ptr.
module d_arb_pick #(
  parameter int CH_NUM = 4,
  parameter int ID_W   = 2
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  input  logic              mode,
  output logic              any,
  output logic [ID_W-1:0]   win
);
  int base;
  int off;
  logic [CH_NUM-1:0] rot;
  always_comb begin
    base = mode ? int'(ptr) : 0;
    rot  = CH_NUM'({req, req} >> base);
    off  = 0;
    for (int k = CH_NUM - 1; k >= 0; k--) off = rot[k] ? k : off;
    any  = |req;
    win  = ID_W'((base + off) % CH_NUM);
  end
endmodule

// File: rtl/d_empn_rd_arb.sv
// d_empn_rd_arb: burst-locked arbiter sharing one input FIFO among CH_NUM consumers.
module d_empn_rd_arb
  import d_arb_defs::*;
#(
  parameter int CH_NUM   = 4,
  parameter int CNT_W    = 16,
  parameter int ARB_MODE = 0,
  localparam int ID_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    empty_n_from_gi,
  output logic                    read_for_gi,
  input  logic [CH_NUM-1:0]       ch_req,
  input  logic [CH_NUM*CNT_W-1:0] ch_len,
  output logic [CH_NUM-1:0]       ch_empty_n,
  input  logic [CH_NUM-1:0]       ch_read,
  output logic [CH_NUM-1:0]       ch_done,
  output logic                    grant_vld,
  output logic [ID_W-1:0]         grant_id,
  output logic                    rd_err
);
  arb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0] gid_q, gid_d, ptr_q, ptr_d, win;
  logic rd_err_q, rd_err_d, any, busy, xfer;
  logic [CH_NUM-1:0] sel;
  logic [CNT_W-1:0] len_a [CH_NUM];
  for (genvar g = 0; g < CH_NUM; g++) begin : g_len
    assign len_a[g] = ch_len[g*CNT_W +: CNT_W];
  end
  d_arb_pick #(.CH_NUM(CH_NUM), .ID_W(ID_W)) u_pick (
    .req (ch_req),
    .ptr (ptr_q),
    .mode(ARB_MODE == ARB_RR),
    .any (any),
    .win (win)
  );
  assign busy        = state_q == ARB_BUSY;
  assign sel         = CH_NUM'(1) << gid_q;
  assign xfer        = busy & empty_n_from_gi & ch_read[gid_q];
  assign read_for_gi = xfer;
  assign ch_empty_n  = (busy & empty_n_from_gi) ? sel : '0;
  assign ch_done     = (state_q == ARB_DONE) ? sel : '0;
  assign grant_vld   = busy;
  assign grant_id    = gid_q;
  assign rd_err      = rd_err_q;
  // a read on any channel not currently offered data is illegal, which also covers a granted read on an empty FIFO
  assign rd_err_d    = rd_err_q | (|(ch_read & ~ch_empty_n));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: if (any) begin
        gid_d   = win;
        cnt_d   = len_a[win];
        state_d = (len_a[win] == '0) ? ARB_DONE : ARB_BUSY;
      end
      ARB_BUSY: if (xfer) begin
        cnt_d   = cnt_q - CNT_W'(cnt_q != '0);
        state_d = (cnt_q == CNT_W'(1)) ? ARB_DONE : ARB_BUSY;
      end else if (!ch_req[gid_q]) begin
        state_d = ARB_IDLE;
      end
      ARB_DONE: begin
        ptr_d   = (gid_q == ID_W'(CH_NUM - 1)) ? '0 : gid_q + ID_W'(1);
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      cnt_q    <= '0;
      gid_q    <= '0;
      ptr_q    <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      rd_err_q <= rd_err_d;
    end
  end
endmodule

// File: tb/tb_d_empn_rd_arb.sv
// tb_d_empn_rd_arb: fixed (u0) and round-robin (u1) arbiters against a burst-level reference model.
module tb_d_empn_rd_arb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic        e [2];
  logic [3:0]  req [2], rdv [2], extra [2], cen [2], done [2];
  logic [63:0] len [2];
  logic        rgi [2], gv [2], err [2];
  logic [1:0]  gid [2];
  bit          aut [2];
  d_empn_rd_arb #(.CH_NUM(4), .CNT_W(16), .ARB_MODE(0)) u0 (
    .clk(clk), .reset(reset), .empty_n_from_gi(e[0]), .read_for_gi(rgi[0]),
    .ch_req(req[0]), .ch_len(len[0]), .ch_empty_n(cen[0]), .ch_read(rdv[0]),
    .ch_done(done[0]), .grant_vld(gv[0]), .grant_id(gid[0]), .rd_err(err[0]));
  d_empn_rd_arb #(.CH_NUM(4), .CNT_W(16), .ARB_MODE(1)) u1 (
    .clk(clk), .reset(reset), .empty_n_from_gi(e[1]), .read_for_gi(rgi[1]),
    .ch_req(req[1]), .ch_len(len[1]), .ch_empty_n(cen[1]), .ch_read(rdv[1]),
    .ch_done(done[1]), .grant_vld(gv[1]), .grant_id(gid[1]), .rd_err(err[1]));
  // model: phase 0 waiting, 1 transferring, 2 completion beat
  int ph [2], mg [2], rem [2], mp [2], rdcnt [2];
  bit me [2], pb [2];
  int total = 0, bad = 0, cyc = 0;
  int gq0 [$], gq1 [$], gc1 [$];
  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++)
      if (((r >> ((p + k) % 4)) & 4'd1) != 4'd0) return (p + k) % 4;
    return -1;
  endfunction
  task automatic chk(string tag, int k, logic [31:0] o, logic [31:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s[u%0d] cyc=%0d got=%0h exp=%0h", tag, k, cyc, o, x);
    end
  endtask
  task automatic tick();
    bit busy, xf;
    logic [3:0] offer;
    int w;
    #1;
    for (int k = 0; k < 2; k++) if (aut[k]) rdv[k] = cen[k] | extra[k];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      busy  = ph[k] == 1;
      offer = (busy && e[k]) ? 4'(1 << mg[k]) : 4'd0;
      xf    = busy && e[k] && (((rdv[k] >> mg[k]) & 4'd1) != 4'd0);
      chk("read_for_gi", k, 32'(rgi[k]), 32'(xf));
      chk("ch_empty_n", k, 32'(cen[k]), 32'(offer));
      chk("ch_done", k, 32'(done[k]), (ph[k] == 2) ? 32'(1 << mg[k]) : 32'd0);
      chk("grant_vld", k, 32'(gv[k]), 32'(busy));
      chk("grant_id", k, 32'(gid[k]), 32'(mg[k]));
      chk("rd_err", k, 32'(err[k]), 32'(me[k]));
      if (xf) rdcnt[k]++;
      if (busy && !pb[k]) begin
        if (k == 0) gq0.push_back(mg[k]);
        else begin gq1.push_back(mg[k]); gc1.push_back(cyc); end
      end
      pb[k] = busy;
      if (reset) begin
        ph[k] = 0; mg[k] = 0; rem[k] = 0; mp[k] = 0; me[k] = 0;
      end else begin
        me[k] = me[k] | ((rdv[k] & ~offer) != 4'd0);
        if (ph[k] == 0) begin
          w = pick(req[k], (k == 1) ? mp[k] : 0);
          if (w >= 0) begin
            mg[k]  = w;
            rem[k] = int'(len[k][w*16 +: 16]);
            ph[k]  = (rem[k] == 0) ? 2 : 1;
          end
        end else if (ph[k] == 1) begin
          if (xf) begin
            rem[k]--;
            if (rem[k] == 0) ph[k] = 2;
          end else if (((req[k] >> mg[k]) & 4'd1) == 4'd0) ph[k] = 0;
        end else begin
          mp[k] = (mg[k] + 1) % 4;
          ph[k] = 0;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic settle(int k);
    for (int n = 0; n < 40 && ph[k] != 0; n++) tick();
    chk("settle", k, 32'(ph[k]), 32'd0);
  endtask
  int base, r1, n0;
  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      e[k] = 1'b0; req[k] = '0; rdv[k] = '0; extra[k] = '0; len[k] = '0; aut[k] = 1'b0;
      ph[k] = 0; mg[k] = 0; rem[k] = 0; mp[k] = 0; me[k] = 0; pb[k] = 0; rdcnt[k] = 0;
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    // fixed priority: ch1 (3 beats) beats ch2; ch2 granted once ch1 withdraws
    req[0] = 4'b0110; len[0] = {16'd1, 16'd2, 16'd3, 16'd1}; e[0] = 1'b1; aut[0] = 1'b1;
    base = rdcnt[0]; r1 = -1;
    for (int n = 0; n < 40 && gq0.size() < 2; n++) begin
      tick();
      if (done[0] == 4'b0010 && req[0][1]) begin r1 = rdcnt[0] - base; req[0] = 4'b0100; end
    end
    chk("fix_grants", 0, 32'(gq0.size() >= 2), 32'd1);
    chk("fix_first", 0, 32'(gq0[0]), 32'd1);
    chk("fix_beats", 0, 32'(r1), 32'd3);
    chk("fix_second", 0, 32'(gq0[1]), 32'd2);
    req[0] = '0;
    settle(0);
    // round robin: four single-beat channels served in rotation
    req[1] = 4'hf; len[1] = {4{16'd1}}; e[1] = 1'b1; aut[1] = 1'b1;
    for (int n = 0; n < 60 && gq1.size() < 5; n++) tick();
    req[1] = '0;
    chk("rr_grants", 1, 32'(gq1.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) chk("rr_order", 1, 32'(gq1[i]), 32'(i % 4));
    for (int i = 0; i < 4; i++) chk("rr_spacing", 1, 32'(gc1[i+1] - gc1[i]), 32'd3);
    settle(1);
    // FIFO stall after two of four beats
    req[0] = 4'b0001; len[0] = {48'd0, 16'd4};
    base = rdcnt[0];
    for (int n = 0; n < 20 && rdcnt[0] - base < 2; n++) tick();
    e[0] = 1'b0;
    repeat (5) tick();
    chk("stall_hold", 0, 32'(rdcnt[0] - base), 32'd2);
    e[0] = 1'b1;
    for (int n = 0; n < 20 && done[0] != 4'b0001; n++) tick();
    chk("stall_done", 0, 32'(done[0]), 32'h1);
    req[0] = '0;
    chk("stall_beats", 0, 32'(rdcnt[0] - base), 32'd4);
    chk("stall_err", 0, 32'(err[0]), 32'd0);
    settle(0);
    // illegal read on ch3 while ch0 holds the grant
    req[0] = 4'b0001; len[0] = {48'd0, 16'd3};
    base = rdcnt[0];
    tick(); tick();
    extra[0] = 4'b1000;
    tick();
    extra[0] = '0;
    for (int n = 0; n < 20 && done[0] != 4'b0001; n++) tick();
    req[0] = '0;
    tick();
    chk("ill_err", 0, 32'(err[0]), 32'd1);
    chk("ill_beats", 0, 32'(rdcnt[0] - base), 32'd3);
    settle(0);
    // zero-length grant completes without any transfer
    req[1] = 4'b0100; len[1] = {16'd1, 16'd0, 16'd1, 16'd1};
    base = rdcnt[1];
    tick();
    chk("zero_done", 1, 32'(done[1]), 32'h4);
    req[1] = '0;
    tick();
    chk("zero_beats", 1, 32'(rdcnt[1] - base), 32'd0);
    chk("zero_once", 1, 32'(done[1]), 32'd0);
    // abort: request withdrawn after 1 of 5 beats
    req[0] = 4'b0001; len[0] = {48'd0, 16'd5};
    tick(); tick();
    aut[0] = 1'b0; rdv[0] = '0; req[0] = '0;
    tick();
    chk("abort_vld", 0, 32'(gv[0]), 32'd0);
    chk("abort_done", 0, 32'(done[0]), 32'd0);
    tick();
    chk("abort_done2", 0, 32'(done[0]), 32'd0);
    aut[0] = 1'b1;
    // reset after 2 of 6 beats on u1; pointer returns to 0
    req[1] = 4'hf; len[1] = {4{16'd6}};
    base = rdcnt[1];
    for (int n = 0; n < 20 && rdcnt[1] - base < 2; n++) tick();
    chk("rst_prev_gid", 1, 32'(gq1[gq1.size()-1]), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_vld", 1, 32'(gv[1]), 32'd0);
    chk("rst_read", 1, 32'(rgi[1]), 32'd0);
    chk("rst_gid", 1, 32'(gid[1]), 32'd0);
    n0 = gq1.size();
    for (int n = 0; n < 10 && gq1.size() == n0; n++) tick();
    chk("rst_regrant", 1, 32'(gq1[n0]), 32'd0);
    req[1] = '0;
    settle(1);
    // randomized traffic on both arbiters
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        req[k]   = 4'($urandom_range(0, 15));
        e[k]     = ($urandom_range(0, 3) != 0);
        extra[k] = ($urandom_range(0, 40) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        if ($urandom_range(0, 7) == 0)
          len[k] = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
                    16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
      end
      reset = ($urandom_range(0, 150) == 0);
      tick();
    end
    reset = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/d_empn_rd_arb.md
# d_empn_rd_arb

Parametrised arbiter and multiplexer between the shared input FIFO handshake (`empty_n_from_gi` / `read_for_gi`) and `CH_NUM` write-module consumers (input feature, kernel, bias and future channels). The FSM replaces state-decoded routing with a registered, burst-locked grant. Each grant lasts exactly a programmed number of beats, reports a completion pulse, and then re-arbitrates under fixed or round-robin priority. Illegal consumer reads are detected and flagged.

## Interface
- `CH_NUM`, default 4: number of consumer channels, 2..16.
- `CNT_W`, default 16: beat-count width.
- `ARB_MODE`, default 0: arbitration policy.
  - 0: fixed priority, lowest index wins.
  - 1: round-robin.
- `ID_W` (localparam): `max(1, $clog2(CH_NUM))`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `empty_n_from_gi`  in  1  input FIFO not-empty.
- `read_for_gi`  out  1  input FIFO read strobe.
- `ch_req`  in  CH_NUM  per-channel level request (write-module enable).
- `ch_len`  in  CH_NUM*CNT_W  beats per grant; channel i is at `[i*CNT_W +: CNT_W]`.
- `ch_empty_n`  out  CH_NUM  gated empty_n to each consumer.
- `ch_read`  in  CH_NUM  read from each consumer.
- `ch_done`  out  CH_NUM  one-cycle burst-complete pulse.
- `grant_vld`  out  1  a burst is in progress.
- `grant_id`  out  ID_W  index of the granted channel.
- `rd_err`  out  1  sticky illegal-read flag.

## Operation
- States: `IDLE`, `BUSY`, `DONE`.
- `IDLE`:
  - If `ch_req` is nonzero, select the winner `w`, latch `grant_id <= w` and `cnt <= ch_len[w]`.
  - If `ch_len[w] == 0`, go to `DONE` with no transfer. Otherwise go to `BUSY`.
- Winner selection:
  - Fixed mode: lowest set bit of `ch_req`.
  - Round-robin mode: first set bit at or above `rr_ptr`, wrapping modulo `CH_NUM`.
- `BUSY`:
  - `ch_empty_n[grant_id] = empty_n_from_gi`. All other `ch_empty_n` bits are 0.
  - `read_for_gi = ch_read[grant_id] & empty_n_from_gi`.
  - A transfer is a cycle with `read_for_gi = 1`. Each transfer decrements `cnt`.
  - When a transfer occurs with `cnt == 1`, go to `DONE`.
  - If `ch_req[grant_id]` is 0 in any BUSY cycle without a transfer, abort: go to `IDLE`, with no `ch_done` pulse and no `rr_ptr` update.
  - If the request drop and the final transfer happen in the same cycle, the transfer completes normally and goes to `DONE`.
- `DONE` (one cycle):
  - `ch_done[grant_id] = 1`.
  - `rr_ptr <= (grant_id + 1) mod CH_NUM`.
  - Go to `IDLE`.
- Outside `BUSY`: `read_for_gi = 0` and all `ch_empty_n` bits are 0.
- `rd_err` sets when either of these occurs, and clears only on `reset`:
  - any `ch_read[i]` is asserted while `ch_empty_n[i] == 0`;
  - `ch_read[grant_id]` is asserted while `empty_n_from_gi == 0`.
- `cnt` counts down with no wrap. `ch_len` is sampled only in `IDLE` at grant; later changes are ignored.

## Timing
- Reset values:
  - state `IDLE`, `cnt = 0`, `rr_ptr = 0`, `grant_id = 0`;
  - `grant_vld = 0`, `rd_err = 0`;
  - `ch_done = 0`, `ch_empty_n = 0`, `read_for_gi = 0`.
- Reset asserted mid-burst returns to these values on the next edge. Any beats remaining in the FIFO are left unread.
- Grant latency: `ch_req` is seen in `IDLE` at cycle t; `BUSY` starts at t+1, where the first transfer is possible.
- `read_for_gi` and `ch_empty_n` are combinational from registered state plus `empty_n_from_gi` / `ch_read`, with zero latency. This matches the FIFO's same-cycle read semantics.
- `ch_done` pulses in the cycle after the last transfer.
- `grant_vld = 1` only in `BUSY`.
- Back-to-back bursts have a 2-cycle gap (`DONE`, then `IDLE`).
- Throughput within a burst is one beat per cycle while the FIFO is non-empty and the consumer reads.
- If `empty_n_from_gi` drops mid-burst, the FSM stays in `BUSY` and holds `cnt`.

## Structure
- Shared package / header `d_arb_defs`:
  - state encodings `ARB_IDLE = 2'd0`, `ARB_BUSY = 2'd1`, `ARB_DONE = 2'd2`;
  - `ARB_MODE` constants `ARB_FIXED = 0`, `ARB_RR = 1`.
- Sub-module `d_arb_pick`: purely combinational priority picker.
  - Inputs: `req[CH_NUM]`, `ptr[ID_W]`, `mode`.
  - Outputs: `any`, `win[ID_W]`.
  - Fixed mode ties `ptr` to 0.
- Top level holds the FSM, beat counter, `rr_ptr`, the gating/mux logic and the `rd_err` logic.

## Test plan
- **Fixed priority:** `ARB_MODE=0`, `ch_req=4'b0110`, `ch_len[1]=3`, FIFO always non-empty, consumer reads every cycle.
  - Expect `grant_id=1`, three `read_for_gi` pulses, then `ch_done=4'b0010`, then a grant to channel 2.
- **Round-robin:** `ARB_MODE=1`, `ch_req=4'b1111`, all `ch_len=1`.
  - Expect grant order 0, 1, 2, 3, 0, one `ch_done` per grant, with a 2-cycle gap between bursts.
- **FIFO stall:** `ch_len=4`, `empty_n_from_gi` low for 5 cycles after beat 2.
  - Expect `cnt` held at 2 and `read_for_gi=0` during the stall, `ch_done` after beat 4, and `rd_err` stays 0.
- **Illegal read:** `ch_read[3]=1` while channel 0 is granted.
  - Expect `rd_err=1`, `read_for_gi` unaffected, and `rd_err` still 1 after the burst ends.
- **Zero length and abort:**
  - `ch_len[2]=0` with `ch_req=4'b0100`: `ch_done[2]` pulses at cycle t+1 and no reads occur.
  - Separately, drop `ch_req[0]` after 1 of 5 beats: FSM goes to `IDLE` with no `ch_done`.
- **Reset mid-burst:** assert `reset` for 1 cycle after beat 2 of 6.
  - Expect all outputs at reset values on the next cycle and re-arbitration from `rr_ptr=0`.
